// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the node-storage bram arbiter and its round-robin picker.
package bram_arb_pkg;

  localparam int MAX_REQ = 8;

  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Wide enough for any legal requester count so the picker stays reusable.
  localparam int PTR_WIDTH = ptr_width(MAX_REQ);

  typedef logic [PTR_WIDTH-1:0] req_id_t;

  // Wrap by compare so non-power-of-two requester counts work.
  function automatic req_id_t next_ptr(input req_id_t id, input int n);
    return (int'(id) >= n - 1) ? req_id_t'(0) : id + req_id_t'(1);
  endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Requester channels plus bram bus of the node-storage arbiter; slave = arbiter side.
interface bram_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic [ADDR_WIDTH-1:0]         mem_address;
  logic                          mem_write_enable;
  logic [DATA_WIDTH-1:0]         mem_write_data;
  logic [DATA_WIDTH-1:0]         mem_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_data, mem_address, mem_write_enable, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_data, mem_address, mem_write_enable, mem_write_data
  );
endinterface

// File: rtl/bram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select, first set request at or after ptr (mod N).
module rr_pick
  import bram_arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  input  req_id_t      ptr_i,
  output logic [N-1:0] grant_o,
  output req_id_t      id_o,
  output logic         any_o
);

  logic [PTR_WIDTH:0] sum;
  logic [PTR_WIDTH:0] idx;
  logic               hit;

  // Scan N slots starting at ptr; first valid slot wins.
  always_comb begin
    grant_o = '0;
    id_o    = req_id_t'(0);
    any_o   = 1'b0;
    sum     = '0;
    idx     = '0;
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (PTR_WIDTH+1)'(k);
      idx = (sum >= (PTR_WIDTH+1)'(N)) ? sum - (PTR_WIDTH+1)'(N) : sum;
      for (int j = 0; j < N; j++) begin
        hit        = !any_o && (idx == (PTR_WIDTH+1)'(j)) && req_i[j];
        grant_o[j] = grant_o[j] | hit;
        id_o       = hit ? req_id_t'(j) : id_o;
        any_o      = any_o | hit;
      end
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port bram among NUM_REQ requesters.
// Define BRAM_ARB_PERF_EN to add per-requester grant/stall counters.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_arbiter_if.slave        bus
`ifdef BRAM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0] grant_count,
  output logic [NUM_REQ*32-1:0] stall_count
`endif
);

  logic [NUM_REQ-1:0]    req_gated;
  logic [NUM_REQ-1:0]    grant;
  req_id_t               win_id;
  logic                  any_grant;
  logic                  win_is_write;

  req_id_t               ptr_q, ptr_d;
  logic                  rd_pend_q, rd_pend_d;
  req_id_t               rd_id_q, rd_id_d;

  logic [ADDR_WIDTH-1:0] mem_addr_mux;
  logic [DATA_WIDTH-1:0] mem_wdata_mux;
  logic                  mem_we_mux;
  logic [NUM_REQ-1:0]    resp_vec;

  // Requests are masked during reset so nothing is granted or written.
  assign req_gated = rst ? '0 : bus.req_valid;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (req_gated),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .id_o    (win_id),
    .any_o   (any_grant)
  );

  assign win_is_write = |(grant & bus.req_write);

  // OR-mux of the winner's slice; zeros when nobody is granted.
  always_comb begin
    mem_addr_mux  = '0;
    mem_wdata_mux = '0;
    mem_we_mux    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mem_addr_mux  = mem_addr_mux  | (grant[i] ? bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : '0);
      mem_wdata_mux = mem_wdata_mux | (grant[i] ? bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : '0);
      mem_we_mux    = mem_we_mux    | (grant[i] & bus.req_write[i]);
    end
  end

  always_comb begin
    ptr_d     = any_grant ? next_ptr(win_id, NUM_REQ) : ptr_q;
    rd_pend_d = any_grant && !win_is_write;
    rd_id_d   = (any_grant && !win_is_write) ? win_id : rd_id_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= req_id_t'(0);
      rd_pend_q <= 1'b0;
      rd_id_q   <= req_id_t'(0);
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  always_comb begin
    resp_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_vec[i] = rd_pend_q && (rd_id_q == req_id_t'(i));
    end
  end

  assign bus.req_ready        = grant;
  assign bus.mem_address      = mem_addr_mux;
  assign bus.mem_write_data   = mem_wdata_mux;
  assign bus.mem_write_enable = mem_we_mux;
  assign bus.resp_valid       = resp_vec;
  assign bus.resp_data        = bus.mem_read_data;

`ifdef BRAM_ARB_PERF_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters: stop at all-ones instead of wrapping.
    always_comb begin
      grant_cnt_d = (grant[g] && (grant_cnt_q != 32'hFFFF_FFFF)) ? grant_cnt_q + 32'd1 : grant_cnt_q;
      stall_cnt_d = (req_gated[g] && !grant[g] && (stall_cnt_q != 32'hFFFF_FFFF))
                    ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        grant_cnt_q <= 32'd0;
        stall_cnt_q <= 32'd0;
      end else begin
        grant_cnt_q <= grant_cnt_d;
        stall_cnt_q <= stall_cnt_d;
      end
    end

    assign grant_count[g*32 +: 32] = grant_cnt_q;
    assign stall_count[g*32 +: 32] = stall_cnt_q;
  end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: stimulus queues expected grants/responses, monitor checks.
module tb_bram_arbiter;

  localparam int NR = 3;
  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic [NR-1:0] id;
    logic [DW-1:0] data;
  } resp_t;

  logic clk;
  logic rst;

  bram_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef BRAM_ARB_PERF_EN
  logic [NR*32-1:0] grant_count;
  logic [NR*32-1:0] stall_count;
`endif

  bram_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BRAM_ARB_PERF_EN
    ,
    .grant_count (grant_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port bram with 1-cycle registered read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
    rdata_q <= mem[bus.mem_address];
  end
  assign bus.mem_read_data = rdata_q;

  int n_cmp = 0;
  int n_bad = 0;
  logic [NR-1:0] sb_grant [$];
  resp_t         sb_resp  [$];
  int            gcnt [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]          = v;
    bus.req_write[i]          = w;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic exp_read(input logic [NR-1:0] id, input logic [DW-1:0] d);
    resp_t r;
    r.id   = id;
    r.data = d;
    sb_grant.push_back(id);
    sb_resp.push_back(r);
  endtask

  // Monitor: every grant and every read response is matched against the queues.
  always @(negedge clk) begin
    logic [NR-1:0] eg;
    resp_t er;
    if (bus.req_ready != '0) begin
      for (int i = 0; i < NR; i++) if (bus.req_ready[i]) gcnt[i]++;
      if (sb_grant.size() == 0) begin
        chk("grant_unexpected", 64'(bus.req_ready), 64'd0);
      end else begin
        eg = sb_grant.pop_front();
        chk("grant_vec", 64'(bus.req_ready), 64'(eg));
      end
    end
    if (bus.resp_valid != '0) begin
      if (sb_resp.size() == 0) begin
        chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
      end else begin
        er = sb_resp.pop_front();
        chk("resp_id", 64'(bus.resp_valid), 64'(er.id));
        chk("resp_data", 64'(bus.resp_data), 64'(er.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int snap [NR];
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[1] = 32'h0000_0011;
    mem[2] = 32'h0000_0022;
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // Reset held with requests pending: nothing may be granted or written.
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(i + 8), 32'hA5A5_0000 + DW'(i));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_we", 64'(bus.mem_write_enable), 64'd0);
      chk("rst_resp", 64'(bus.resp_valid), 64'd0);
      tick();
    end
    rst = 1'b0;
    bus.req_valid = '0;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_ready", 64'(bus.req_ready), 64'd0);
      chk("idle_we", 64'(bus.mem_write_enable), 64'd0);
      chk("idle_addr", 64'(bus.mem_address), 64'd0);
      chk("idle_resp", 64'(bus.resp_valid), 64'd0);
      tick();
    end

    // Single write then read of the same address.
    set_req(0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
    sb_grant.push_back(3'b001);
    @(negedge clk);
    chk("wr_addr", 64'(bus.mem_address), 64'd5);
    chk("wr_we", 64'(bus.mem_write_enable), 64'd1);
    chk("wr_data", 64'(bus.mem_write_data), 64'hDEAD_BEEF);
    tick();
    set_req(0, 1'b1, 1'b0, 10'd5, 32'h0);
    exp_read(3'b001, 32'hDEAD_BEEF);
    tick();
    set_req(0, 1'b0, 1'b0, 10'd0, 32'h0);

    // Pipelined reads routed to different requesters, then same requester back-to-back.
    set_req(1, 1'b1, 1'b0, 10'd1, 32'h0);
    exp_read(3'b010, 32'h0000_0011);
    tick();
    set_req(1, 1'b0, 1'b0, 10'd0, 32'h0);
    set_req(2, 1'b1, 1'b0, 10'd2, 32'h0);
    exp_read(3'b100, 32'h0000_0022);
    tick();
    set_req(2, 1'b1, 1'b0, 10'd5, 32'h0);
    exp_read(3'b100, 32'hDEAD_BEEF);
    tick();
    set_req(2, 1'b1, 1'b0, 10'd1, 32'h0);
    exp_read(3'b100, 32'h0000_0011);
    tick();
    set_req(2, 1'b0, 1'b0, 10'd0, 32'h0);
    tick();

    // Three-way contention from ptr=0 (last grant went to req2, wrapping to 0).
    for (int i = 0; i < NR; i++) snap[i] = gcnt[i];
    set_req(0, 1'b1, 1'b0, 10'd5, 32'h0);
    set_req(1, 1'b1, 1'b0, 10'd1, 32'h0);
    set_req(2, 1'b1, 1'b0, 10'd2, 32'h0);
    exp_read(3'b001, 32'hDEAD_BEEF); exp_read(3'b010, 32'h11); exp_read(3'b100, 32'h22);
    exp_read(3'b001, 32'hDEAD_BEEF); exp_read(3'b010, 32'h11); exp_read(3'b100, 32'h22);
    exp_read(3'b001, 32'hDEAD_BEEF); exp_read(3'b010, 32'h11); exp_read(3'b100, 32'h22);
    repeat (9) tick();
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) chk("fair_grants", 64'(gcnt[i] - snap[i]), 64'd3);

    // Write followed next cycle by a read of the same address.
    set_req(1, 1'b1, 1'b1, 10'd7, 32'hCAFE_F00D);
    sb_grant.push_back(3'b010);
    tick();
    set_req(1, 1'b1, 1'b0, 10'd7, 32'h0);
    exp_read(3'b010, 32'hCAFE_F00D);
    tick();
    set_req(1, 1'b0, 1'b0, 10'd0, 32'h0);
    repeat (2) tick();

    // Reset right after a read is accepted: response must be dropped.
    set_req(0, 1'b1, 1'b0, 10'd5, 32'h0);
    sb_grant.push_back(3'b001);
    tick();
    set_req(0, 1'b0, 1'b0, 10'd0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrd_resp", 64'(bus.resp_valid), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_resp", 64'(bus.resp_valid), 64'd0);
    tick();

    // ptr must be 0 again: req0 wins first, then alternation.
    set_req(0, 1'b1, 1'b1, 10'd20, 32'h0000_0020);
    set_req(1, 1'b1, 1'b1, 10'd21, 32'h0000_0021);
    sb_grant.push_back(3'b001); sb_grant.push_back(3'b010);
    sb_grant.push_back(3'b001); sb_grant.push_back(3'b010);
    repeat (4) tick();
    bus.req_valid = '0;

`ifdef BRAM_ARB_PERF_EN
    chk("perf_grant0", 64'(grant_count[0*32 +: 32]), 64'd2);
    chk("perf_grant1", 64'(grant_count[1*32 +: 32]), 64'd2);
    chk("perf_grant2", 64'(grant_count[2*32 +: 32]), 64'd0);
    chk("perf_stall0", 64'(stall_count[0*32 +: 32]), 64'd2);
    chk("perf_stall1", 64'(stall_count[1*32 +: 32]), 64'd2);
    chk("perf_stall2", 64'(stall_count[2*32 +: 32]), 64'd0);
`endif

    for (int c = 0; c < 20 && (sb_grant.size() != 0 || sb_resp.size() != 0); c++) tick();
    repeat (2) tick();
    chk("grant_queue_drained", 64'(sb_grant.size()), 64'd0);
    chk("resp_queue_drained", 64'(sb_resp.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port bram (1-cycle registered read, write-first-cycle semantics irrelevant) between NUM_REQ requesters, e.g. tree-node writer, nearest-neighbour search, and host readback.
- Per-requester valid/ready request channel; round-robin grant, at most one access per cycle.
- Read data is routed back to the requester that issued the read, with a fixed latency.
- Sits between the RRT compute units and the node-storage bram.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 10, bram address width.
- DATA_WIDTH, 32, bram word width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- resp_valid  out  NUM_REQ  read data valid for requester i; one-hot or zero.
- resp_data  out  DATA_WIDTH  read data, shared by all requesters, qualified by resp_valid.
- mem_address  out  ADDR_WIDTH  to bram bus address.
- mem_write_enable  out  1  to bram bus write_enable.
- mem_write_data  out  DATA_WIDTH  to bram bus write_data.
- mem_read_data  in  DATA_WIDTH  from bram bus read_data; valid 1 cycle after address.

Behaviour:
- Grant is combinational from req_valid and the priority pointer ptr.
  - Winner = first i with req_valid[i] set, searching ptr, ptr+1, … mod NUM_REQ.
  - req_ready[winner] = 1; all other req_ready bits are 0.
- Transfer occurs when req_valid[i] && req_ready[i]. Requesters hold valid, addr, write and wdata stable until ready.
- Memory outputs while granted: mem_address = winner's addr; mem_write_data = winner's wdata; mem_write_enable = winner's write.
- Memory outputs with no grant: mem_write_enable = 0, mem_address = 0, mem_write_data = 0.
- Pointer update: on any transfer, ptr <= (winner + 1) mod NUM_REQ. With no transfer, ptr holds.
  - Any continuously-valid requester is served within NUM_REQ cycles.
- Read tracking registers: rd_pend (1 bit) and rd_id.
  - On a read transfer at edge T: rd_pend <= 1, rd_id <= winner. Otherwise rd_pend <= 0.
- Read response timing:
  - resp_valid[rd_id] = rd_pend; resp_data = mem_read_data (combinational pass-through).
  - Read latency is exactly 1 cycle after the accepting edge.
  - Back-to-back reads (including by the same requester) are fully pipelined; throughput is 1 access per cycle.
- Writes produce no response; they are complete at the accepting edge.
  - A read of the same address accepted in the following cycle returns the new data.
- Simultaneous requests: only the winner is served; losers keep valid asserted and ready stays 0 for them.
- Reset: ptr = 0, rd_pend = 0.
  - While rst is high: all req_ready = 0, resp_valid = 0, mem_write_enable = 0.
  - Reset asserted mid-read drops the pending response; no resp_valid appears after release.
- ptr wrap-around: NUM_REQ-1 → 0. NUM_REQ is not required to be a power of two; wrap by compare, not truncation.

Optional Feature:
- Macro: BRAM_ARB_PERF_EN.
- Defined: adds output ports
  - grant_count, NUM_REQ*32, per-requester accepted transfers.
  - stall_count, NUM_REQ*32, per-requester cycles with req_valid=1 and req_ready=0.
  - Counters saturate at all-ones and clear on rst.
- Undefined: these ports and counters do not exist; arbitration behaviour is identical.

Decomposition:
- Shared package bram_arb_pkg holds:
  - localparam PTR_WIDTH = $clog2(NUM_REQ) helper function.
  - typedef req_id_t.
  - Function next_ptr(id, n) for modular increment.
- Sub-module rr_pick (combinational round-robin priority select):
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant, encoded id, any_grant.
  - Reusable by other arbiters in the design.
- Top holds ptr, rd_pend, rd_id, the memory mux and the optional counters.

Test Plan:
- Reset then idle: rst high 3 cycles, then low with no valid → req_ready=0, resp_valid=0, mem_write_enable=0 every cycle.
- Single write then read: req0 write addr 5 data 0xDEADBEEF accepted cycle 1; req0 read addr 5 accepted cycle 2 → resp_valid[0]=1 in cycle 3, resp_data=0xDEADBEEF.
- Contention fairness: all three requesters hold valid continuously for 9 cycles from ptr=0 → grant order 0,1,2,0,1,2,0,1,2; each requester gets 3 grants.
- Pipelined reads with routing: req1 reads addr 1 and req2 reads addr 2 on consecutive cycles (memory preloaded 0x11, 0x22) → resp_valid[1] with 0x11, then resp_valid[2] with 0x22 the next cycle.
- Reset mid-read: read accepted, rst asserted before the next edge → no resp_valid after release, ptr=0.
- With BRAM_ARB_PERF_EN: req0 and req1 both valid for 4 cycles → grant_count = 2,2; stall_count = 2,2 (first winner is req0, so req1 stalls in cycles 1 and 3, req0 in cycles 2 and 4).
